// File: rtl/uart8_transmitter_pkg.sv
// rtl/uart8_transmitter_pkg.sv - shared UART state codes and frame constants (UART_TX_PARITY_EN adds parity)
package uart8_transmitter_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_N        = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Receiver codes occupy 0..2; transmit-only codes are appended above them.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DATA_BITS  = 3'd1,
    STOP_BIT   = 3'd2,
`ifdef UART_TX_PARITY_EN
    START_BIT  = 3'd3,
    PARITY_BIT = 3'd4
`else
    START_BIT  = 3'd3
`endif
  } uart_state_t;

  function automatic int frame_clocks(input int oversample);
    return oversample * FRAME_BITS;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - oversample tick counter; wrap marks the last clock of a bit period
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  output logic [$clog2(OVERSAMPLE)-1:0] count,
  output logic                          wrap
);

  localparam int W = $clog2(OVERSAMPLE);
  localparam logic [W-1:0] LAST = W'(OVERSAMPLE - 1);

  assign wrap = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || wrap) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart8_transmitter.sv
// rtl/uart8_transmitter.sv - 8-bit UART transmitter with one-entry holding buffer
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart8_transmitter
  import uart8_transmitter_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] in,
  output logic       out,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  localparam int W = $clog2(OVERSAMPLE);
  localparam logic [W-1:0] PRE_LAST = W'(OVERSAMPLE - 2);
  localparam logic [2:0]   LAST_BIT = 3'(DATA_BITS_N - 1);

  uart_state_t state, state_d;
  logic [7:0]  shift_reg, shift_d;
  logic [7:0]  hold_reg, hold_d;
  logic        hold_full, hold_full_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [W-1:0] tick;
  logic        wrap;
  logic        accept;
  logic        out_d;
  logic        done_d;

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!en || (state == IDLE)),
    .count (tick),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_idx   <= '0;
      out       <= 1'b1;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      shift_reg <= shift_d;
      hold_reg  <= hold_d;
      hold_full <= hold_full_d;
      bit_idx   <= bit_idx_d;
      out       <= out_d;
      ready     <= !hold_full_d;
      busy      <= (state_d != IDLE);
      done      <= done_d;
    end
  end

  always_comb begin
    state_d     = state;
    shift_d     = shift_reg;
    hold_d      = hold_reg;
    hold_full_d = hold_full;
    bit_idx_d   = bit_idx;
    accept      = start && !hold_full;
    // done is registered, so raise it one clock ahead of the stop bit's last tick
    done_d      = (state == STOP_BIT) && (tick == PRE_LAST);

    case (state)
      IDLE: begin
        if (accept) begin
          shift_d   = in;
          bit_idx_d = '0;
          state_d   = START_BIT;
        end
      end
      START_BIT: begin
        if (wrap) begin
          bit_idx_d = '0;
          state_d   = DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (wrap) begin
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY_BIT;
`else
            state_d = STOP_BIT;
`endif
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        if (wrap) begin
          state_d = STOP_BIT;
        end
      end
`endif
      STOP_BIT: begin
        if (wrap) begin
          bit_idx_d = '0;
          if (hold_full) begin
            shift_d     = hold_reg;
            hold_full_d = 1'b0;
            state_d     = START_BIT;
          end else if (accept) begin
            shift_d = in;
            state_d = START_BIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Accepts that do not go straight into the shifter park in the holding buffer.
    if (accept && (state != IDLE) && !((state == STOP_BIT) && wrap)) begin
      hold_d      = in;
      hold_full_d = 1'b1;
    end

    out_d = 1'b1;
    case (state_d)
      START_BIT: out_d = 1'b0;
      DATA_BITS: out_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: out_d = ^shift_d;
`endif
      default: out_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart8_transmitter.sv
// tb/tb_uart8_transmitter.sv - self-checking bench for uart8_transmitter (honours UART_TX_PARITY_EN)
module tb_uart8_transmitter;
  import uart8_transmitter_pkg::*;

  localparam int OS = 16;
  localparam int FL = frame_clocks(OS);

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic [7:0] in_b;
  logic       out_l;
  logic       ready;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[6];

  uart8_transmitter #(.OVERSAMPLE(OS)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .in    (in_b),
    .out   (out_l),
    .ready (ready),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {1'b1, v.par, v.frame[8:0]};
`else
    return {1'b0, v.frame};
`endif
  endfunction

  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check({name, "_out"}, out_l, 1'b1);
      check({name, "_ready"}, ready, 1'b1);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_done"}, done, 1'b0);
      step();
    end
  endtask

  task automatic send(input logic [7:0] d);
    start = 1'b1;
    in_b  = d;
    step();
    start = 1'b0;
    in_b  = 8'h5A;
  endtask

  // t = 0 is the first cycle after the accepting edge
  task automatic run_check(input string name, input int nf,
                           input logic [10:0] fr0, input logic [10:0] fr1,
                           input int hold_t, input logic [7:0] hold_v,
                           input int ign_t, input logic [7:0] ign_v);
    for (int t = 0; t <= nf * FL; t++) begin
      if (t < nf * FL) begin
        int f = t / FL;
        int r = t % FL;
        logic [10:0] fr = (f == 0) ? fr0 : fr1;
        logic exp_ready = !(hold_t >= 0 && t > hold_t && t < FL);
        check({name, "_out"}, out_l, fr[r / OS]);
        check({name, "_busy"}, busy, 1'b1);
        check({name, "_done"}, done, (r == FL - 1));
        check({name, "_ready"}, ready, exp_ready);
      end else begin
        check({name, "_end_out"}, out_l, 1'b1);
        check({name, "_end_busy"}, busy, 1'b0);
        check({name, "_end_done"}, done, 1'b0);
        check({name, "_end_ready"}, ready, 1'b1);
      end
      start = 1'b0;
      if (t == hold_t) begin
        start = 1'b1;
        in_b  = hold_v;
      end
      if (t == ign_t) begin
        start = 1'b1;
        in_b  = ign_v;
      end
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    vec_t v3c;
    vec_t vc3;
    vec_t v00;
    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    in_b  = 8'h00;
    vecs[0] = '{8'hA5, 10'h34A, 1'b0};
    vecs[1] = '{8'h3C, 10'h278, 1'b0};
    vecs[2] = '{8'hC3, 10'h386, 1'b0};
    vecs[3] = '{8'h00, 10'h200, 1'b0};
    vecs[4] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[5] = '{8'h07, 10'h20E, 1'b1};
    v3c = vecs[1];
    vc3 = vecs[2];
    v00 = vecs[3];

    repeat (3) step();
    rst = 1'b0;
    en  = 1'b1;
    check_idle("reset", 8);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data);
      run_check($sformatf("frame%0d", i), 1, mk(vecs[i]), 11'h0, -1, 8'h00, -1, 8'h00);
      check_idle($sformatf("gap%0d", i), 3);
    end

    // back-to-back through the hold, plus a start ignored while hold is full
    send(8'h3C);
    run_check("b2b", 2, mk(v3c), mk(vc3), 40, 8'hC3, 60, 8'hFF);

    // start accepted on the last stop tick goes straight to the shifter
    send(8'hC3);
    run_check("stop_accept", 2, mk(vc3), mk(v00), FL - 1, 8'h00, -1, 8'h00);
    check_idle("post_stop_accept", 3);

    // enable drop during data bit 4 aborts the frame and clears the hold
    send(8'hA5);
    for (int t = 0; t <= 85; t++) begin
      start = (t == 20);
      if (t == 20) in_b = 8'h11;
      if (t == 84) begin
        check("abort_bit4_out", out_l, 1'b0);
        check("abort_ready_before", ready, 1'b0);
      end
      if (t == 85) begin
        start = 1'b0;
        en    = 1'b0;
      end
      step();
    end
    check("abort_out", out_l, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    start = 1'b1;
    in_b  = 8'h22;
    check_idle("en_low_start", 3);
    start = 1'b0;
    en    = 1'b1;
    check_idle("after_abort", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
